// File: rtl/uart_pkg.sv
// Shared constants for the UART receive buffer: register map defaults,
// status bit positions and the interrupt state encoding.
package uart_pkg;

  localparam logic [7:0] ACK_ADDR_DEF  = 8'd252;
  localparam logic [7:0] DATA_ADDR_DEF = 8'd253;
  localparam logic [7:0] STAT_ADDR_DEF = 8'd254;

  localparam int OVR_BIT   = 7;
  localparam int FULL_BIT  = 6;
  localparam int EMPTY_BIT = 5;

  typedef enum logic {
    INT_IDLE = 1'b0,
    INT_PEND = 1'b1
  } int_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == {(AW+1){1'b0}});
  assign full      = (count_r == FULL_CNT);
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer between the UART receiver and the CPU I/O bus,
// with sticky overrun flag and an ack-cleared level interrupt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] DATA_ADDR = DATA_ADDR_DEF,
  parameter logic [7:0] STAT_ADDR = STAT_ADDR_DEF,
  parameter logic [7:0] ACK_ADDR  = ACK_ADDR_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       end_flag,
  input  logic [7:0] access_addr,
  input  logic       reg_w_en,
  input  logic       reg_r_en,
  output logic [7:0] rd_data,
  output logic       int_req,
  output logic       empty,
  output logic       full,
  output logic       overrun
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          end_flag_d_r;
  logic          overrun_r;
  logic          int_req_r;
  int_state_e    int_state_r;
  logic          push_s;
  logic          pop_s;
  logic          ack_s;
  logic          ovf_s;
  logic [7:0]    head_s;
  logic [7:0]    stat_s;
  logic [CW-1:0] count_s;
  logic          empty_s;
  logic          full_s;

  assign push_s = end_flag & ~end_flag_d_r;
  assign pop_s  = reg_r_en & (access_addr == DATA_ADDR) & ~empty_s;
  assign ack_s  = reg_w_en & (access_addr == ACK_ADDR);
  // A full FIFO only drops the byte when no pop frees a slot this cycle.
  assign ovf_s  = push_s & full_s & ~pop_s;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (rx_data),
    .rdata (head_s),
    .count (count_s),
    .empty (empty_s),
    .full  (full_s)
  );

  // Status byte assembly.
  always_comb begin
    stat_s            = 8'h00;
    stat_s[OVR_BIT]   = overrun_r;
    stat_s[FULL_BIT]  = full_s;
    stat_s[EMPTY_BIT] = empty_s;
  end

  // CPU read mux.
  always_comb begin
    rd_data = 8'h00;
    case (access_addr)
      DATA_ADDR: begin
        if (!empty_s) rd_data = head_s;
        else          rd_data = 8'h00;
      end
      STAT_ADDR: rd_data = stat_s;
      default:   rd_data = 8'h00;
    endcase
  end

  // Edge detector history and sticky overrun (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      end_flag_d_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      end_flag_d_r <= end_flag;
      if (ovf_s)      overrun_r <= 1'b1;
      else if (ack_s) overrun_r <= 1'b0;
    end
  end

  // Interrupt FSM: only the ack clears the request, and pending data re-arms it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_state_r <= INT_IDLE;
      int_req_r   <= 1'b0;
    end else begin
      case (int_state_r)
        INT_IDLE: begin
          if (count_s != {CW{1'b0}}) begin
            int_state_r <= INT_PEND;
            int_req_r   <= 1'b1;
          end
        end
        INT_PEND: begin
          if (ack_s) begin
            int_state_r <= INT_IDLE;
            int_req_r   <= 1'b0;
          end
        end
        default: begin
          int_state_r <= INT_IDLE;
          int_req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign int_req = int_req_r;
  assign overrun = overrun_r;
  assign empty   = empty_s;
  assign full    = full_s;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised and directed bench for uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;
  localparam logic [7:0] A_ACK  = 8'd252;
  localparam logic [7:0] A_DATA = 8'd253;
  localparam logic [7:0] A_STAT = 8'd254;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       end_flag = 1'b0;
  logic [7:0] access_addr = 8'h00;
  logic       reg_w_en = 1'b0;
  logic       reg_r_en = 1'b0;
  logic [7:0] rd_data;
  logic       int_req;
  logic       empty;
  logic       full;
  logic       overrun;

  always #10 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .end_flag    (end_flag),
    .access_addr (access_addr),
    .reg_w_en    (reg_w_en),
    .reg_r_en    (reg_r_en),
    .rd_data     (rd_data),
    .int_req     (int_req),
    .empty       (empty),
    .full        (full),
    .overrun     (overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q_m[$];
  logic       ef_d_m = 1'b0;
  logic       ovr_m  = 1'b0;
  logic       int_m  = 1'b0;
  logic [7:0] obs;

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a == A_DATA && q_m.size() != 0) v = q_m[0];
    else if (a == A_STAT) v = {ovr_m, q_m.size() == DEPTH, q_m.size() == 0, 5'b00000};
    return v;
  endfunction

  task automatic model_reset();
    q_m.delete();
    ef_d_m = 1'b0;
    ovr_m  = 1'b0;
    int_m  = 1'b0;
  endtask

  // One clock cycle; called right after a falling edge.
  task automatic step(input logic ef, input logic [7:0] d, input logic [7:0] a,
                      input logic w, input logic r, output logic [7:0] rd_obs);
    int  n;
    logic push, pop, ack, ovf, int_next;
    end_flag = ef; rx_data = d; access_addr = a; reg_w_en = w; reg_r_en = r;
    #1;
    rd_obs = rd_data;
    check_eq("rd_data", rd_data, exp_rd(a));
    @(posedge clk);
    n        = q_m.size();
    push     = ef & ~ef_d_m;
    pop      = r && (a == A_DATA) && (n > 0);
    ack      = w && (a == A_ACK);
    ovf      = push && (n == DEPTH) && !pop;
    int_next = int_m ? !ack : (n != 0);
    if (pop) void'(q_m.pop_front());
    if (push && !ovf) q_m.push_back(d);
    if (ovf) ovr_m = 1'b1;
    else if (ack) ovr_m = 1'b0;
    ef_d_m = ef;
    int_m  = int_next;
    @(negedge clk);
    check_eq("empty", empty, q_m.size() == 0);
    check_eq("full", full, q_m.size() == DEPTH);
    check_eq("overrun", overrun, ovr_m);
    check_eq("int_req", int_req, int_m);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, obs);
  endtask

  task automatic push_byte(input logic [7:0] d);
    step(1'b1, d, 8'h00, 1'b0, 1'b0, obs);
    idle();
  endtask

  task automatic read_data(output logic [7:0] v);
    step(1'b0, 8'h00, A_DATA, 1'b0, 1'b1, v);
  endtask

  task automatic ack();
    step(1'b0, 8'h00, A_ACK, 1'b1, 1'b0, obs);
  endtask

  // Asynchronous reset in the middle of a cycle; called right after a falling edge.
  task automatic do_reset();
    end_flag = 1'b0; reg_w_en = 1'b0; reg_r_en = 1'b0; access_addr = A_DATA;
    #3 rst = 1'b1;
    #1;
    check_eq("rst_empty", empty, 1'b1);
    check_eq("rst_full", full, 1'b0);
    check_eq("rst_int", int_req, 1'b0);
    check_eq("rst_ovr", overrun, 1'b0);
    check_eq("rst_data", rd_data, 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    #1;
    check_eq("por_empty", empty, 1'b1);
    check_eq("por_full", full, 1'b0);
    check_eq("por_int", int_req, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Single byte: empty drops at N+1, interrupt at N+2, survives draining.
    step(1'b1, 8'hA5, 8'h00, 1'b0, 1'b0, obs);
    check_eq("a5_empty_n1", empty, 1'b0);
    check_eq("a5_int_n1", int_req, 1'b0);
    idle();
    check_eq("a5_int_n2", int_req, 1'b1);
    read_data(v);
    check_eq("a5_data", v, 8'hA5);
    check_eq("a5_empty_after", empty, 1'b1);
    idle(); idle();
    check_eq("a5_int_held", int_req, 1'b1);
    ack();
    check_eq("a5_int_acked", int_req, 1'b0);
    idle();

    // Long end_flag is a single push.
    for (int i = 0; i < 5; i++) step(1'b1, 8'h3C, 8'h00, 1'b0, 1'b0, obs);
    idle();
    read_data(v);
    check_eq("hold_data", v, 8'h3C);
    check_eq("hold_empty", empty, 1'b1);
    read_data(v);
    check_eq("hold_empty_read", v, 8'h00);
    ack(); idle();

    // Fill, overflow, drain in order, ack clears overrun.
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    push_byte(8'hFF);
    step(1'b0, 8'h00, A_STAT, 1'b0, 1'b0, v);
    check_eq("ovf_status", v, 8'hC0);
    for (int i = 0; i < 8; i++) begin
      read_data(v);
      check_eq("ovf_order", v, 8'h10 + 8'(i));
    end
    check_eq("ovf_still_set", overrun, 1'b1);
    ack();
    check_eq("ovf_cleared", overrun, 1'b0);
    idle();

    // Full FIFO: simultaneous push and pop, no overrun.
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i));
    step(1'b1, 8'h55, A_DATA, 1'b0, 1'b1, v);
    check_eq("pp_head", v, 8'h20);
    check_eq("pp_full", full, 1'b1);
    check_eq("pp_ovr", overrun, 1'b0);
    idle();
    for (int i = 1; i < 8; i++) begin
      read_data(v);
      check_eq("pp_order", v, 8'h20 + 8'(i));
    end
    read_data(v);
    check_eq("pp_tail", v, 8'h55);
    ack(); idle();

    // Ack with data pending: one-cycle low pulse, then re-asserted.
    push_byte(8'h61);
    push_byte(8'h62);
    check_eq("rearm_pre", int_req, 1'b1);
    ack();
    check_eq("rearm_low", int_req, 1'b0);
    idle();
    check_eq("rearm_high", int_req, 1'b1);
    read_data(v);
    read_data(v);
    ack(); idle(); idle();
    check_eq("rearm_done", int_req, 1'b0);

    // Reset with data buffered.
    push_byte(8'h71); push_byte(8'h72); push_byte(8'h73);
    do_reset();
    read_data(v);
    check_eq("post_rst_data", v, 8'h00);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] a;
      logic       ef, w, r;
      case ($urandom_range(0, 3))
        0:       a = A_ACK;
        1:       a = A_DATA;
        2:       a = A_STAT;
        default: a = 8'($urandom_range(0, 255));
      endcase
      ef = ($urandom_range(0, 99) < 45);
      w  = ($urandom_range(0, 9) == 0);
      r  = ((i % 150) < 75) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 0);
      step(ef, 8'($urandom_range(0, 255)), a, w, r, obs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
